vga_sync_gen: RTL and testbench
===============================

Name: vga_sync_gen

Overview:
- Consumes the 25 MHz pixel-rate enable produced from the 50 MHz system clock and generates 640x480@60 VGA timing.
- Outputs HSync, VSync, a visible-area flag, pixel coordinates, and frame/line start strobes.
- Feeds the espirometro plot renderer and the VGA output pins.
- Single clock domain: all logic runs on Clk and advances only on cycles with PixEn=1.

Parameters:
H_VISIBLE, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_VISIBLE, 480, visible lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BACK, 33, vertical back porch (lines)
SYNC_POL, 0, active level of HSync/VSync (0 = active-low)
CNT_W, 10, width of the coordinate counters

Ports:
Clk  in  1  system clock, 50 MHz
Rst  in  1  synchronous reset, active-high
PixEn  in  1  pixel-rate enable, one Clk cycle wide; any duty is legal, including continuous 1
HSync  out  1  horizontal sync, registered
VSync  out  1  vertical sync, registered
Video_on  out  1  1 while the current pixel is in the visible area, registered
PixelX  out  CNT_W  current horizontal count, 0..H_TOTAL-1
PixelY  out  CNT_W  current vertical count, 0..V_TOTAL-1
LineStart  out  1  one-Clk pulse when PixelX becomes 0
FrameStart  out  1  one-Clk pulse when (PixelX,PixelY) becomes (0,0)

Behaviour:
- Derived totals: H_TOTAL = sum of the H_* parameters = 800. V_TOTAL = sum of the V_* parameters = 525.
- Reset (Rst=1 at a Clk edge; wins over PixEn):
  - PixelX = H_TOTAL-1 (799), PixelY = V_TOTAL-1 (524).
  - HSync = VSync = ~SYNC_POL (inactive), Video_on = 0, LineStart = FrameStart = 0.
  - This is the last blank pixel of a frame, so all outputs are mutually consistent.
- PixEn=0: every output holds, except LineStart and FrameStart, which clear to 0.
- PixEn=1, horizontal counter:
  - PixelX increments; at H_TOTAL-1 it wraps to 0 and asserts an internal h_wrap.
- Vertical counter:
  - Advances only when PixEn & h_wrap.
  - At V_TOTAL-1 it wraps to 0.
- Horizontal phase FSM per pixel, derived from the next PixelX:
  - ACTIVE [0, 639], FRONT [640, 655], SYNC [656, 751], BACK [752, 799].
  - Transitions occur only on PixEn.
- Vertical phase FSM per line, same structure:
  - ACTIVE [0, 479], FRONT [480, 489], SYNC [490, 491], BACK [492, 524].
- Registered outputs are computed from the next counter values. HSync, VSync and Video_on therefore always describe the PixelX/PixelY currently on the outputs, with zero skew.
  - HSync = SYNC_POL in H SYNC, else ~SYNC_POL.
  - VSync = SYNC_POL in V SYNC, else ~SYNC_POL.
  - Video_on = H ACTIVE & V ACTIVE.
- Strobes:
  - LineStart is high for exactly one Clk cycle, the cycle after the PixEn edge that loads PixelX=0.
  - FrameStart is the same, qualified by PixelY=0.
- Rst mid-frame: the next edge returns all outputs to the reset values. The first PixEn after Rst deasserts produces (0,0) with FrameStart=1.
- No other input dependencies. Counter comparisons are unsigned, CNT_W bits. The totals must fit in CNT_W bits; a parameter set that violates this is illegal.

Decomposition:
- Package vga_timing_pkg holds:
  - default timing constants for the H_* and V_* parameters;
  - H_TOTAL / V_TOTAL derivations;
  - the phase enumeration ACTIVE, FRONT, SYNC, BACK.
- One sub-module, vga_axis_timer, with parameters VISIBLE, FRONT, SYNC, BACK and ports Clk, Rst, En, Count, Phase, Wrap.
  - Instantiated twice: horizontal with En=PixEn; vertical with En=PixEn & h_wrap.
  - The top level registers the outputs and the strobes.

Test Plan:
1. Hold Rst 3 cycles with PixEn toggling -> PixelX=799, PixelY=524, HSync=1, VSync=1, Video_on=0, LineStart=FrameStart=0.
2. Release Rst, PixEn every 2nd Clk -> after first PixEn: PixelX=0, PixelY=0, Video_on=1, LineStart=FrameStart=1 for exactly one Clk, then 0.
3. Run one line -> Video_on falls when PixelX=640; HSync=0 for exactly PixelX 656..751 (96 PixEn); LineStart recurs every 800 PixEn.
4. Run two frames -> VSync=0 for exactly PixelY 490..491 (1600 PixEn); FrameStart pulses exactly 420000 PixEn apart; Video_on=0 for all PixelY >= 480.
5. PixEn held 0 for 10 Clk at PixelX=300 -> all outputs frozen and strobes 0; with continuous PixEn=1, the counter advances every Clk.
6. Rst asserted at (300,100) in the same cycle as PixEn -> next cycle shows the reset values, not (301,100); the first PixEn after release yields (0,0) with FrameStart=1.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - default 640x480@60 timing constants and the phase enumeration
package vga_timing_pkg;

    localparam int DEF_H_VISIBLE = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;

    localparam int DEF_V_VISIBLE = 480;
    localparam int DEF_V_FRONT   = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BACK    = 33;

    // Counts per line / per frame; every axis is visible + front + sync + back.
    function automatic int axis_total(input int visible, input int front,
                                      input int sync, input int back);
        return visible + front + sync + back;
    endfunction

    localparam int H_TOTAL = axis_total(DEF_H_VISIBLE, DEF_H_FRONT, DEF_H_SYNC, DEF_H_BACK);
    localparam int V_TOTAL = axis_total(DEF_V_VISIBLE, DEF_V_FRONT, DEF_V_SYNC, DEF_V_BACK);

    typedef enum logic [1:0] {
        PH_ACTIVE = 2'd0,
        PH_FRONT  = 2'd1,
        PH_SYNC   = 2'd2,
        PH_BACK   = 2'd3
    } phase_e;

endpackage

// File: rtl/vga_axis_timer.sv
// rtl/vga_axis_timer.sv - one timing axis: wrapping counter plus active/front/sync/back phase tracker
module vga_axis_timer
    import vga_timing_pkg::*;
#(
    parameter int VISIBLE = DEF_H_VISIBLE,
    parameter int FRONT   = DEF_H_FRONT,
    parameter int SYNC    = DEF_H_SYNC,
    parameter int BACK    = DEF_H_BACK,
    parameter int CNT_W   = 10
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             En,
    output logic [CNT_W-1:0] Count,  // current count, registered
    output phase_e           Phase,  // phase of the count loaded at the next edge
    output logic             Wrap    // current count is the last one; next En wraps to 0
);

    localparam int TOTAL = axis_total(VISIBLE, FRONT, SYNC, BACK);

    localparam logic [CNT_W-1:0] LAST        = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] FRONT_START = CNT_W'(VISIBLE);
    localparam logic [CNT_W-1:0] SYNC_START  = CNT_W'(VISIBLE + FRONT);
    localparam logic [CNT_W-1:0] BACK_START  = CNT_W'(VISIBLE + FRONT + SYNC);

    logic [CNT_W-1:0] count_q, count_d;
    phase_e           phase_q, phase_d;

    // Next count and next phase; both hold when En is low.
    always_comb begin
        count_d = count_q;
        phase_d = phase_q;
        if (En) begin
            count_d = (count_q == LAST) ? '0 : count_q + 1'b1;
            unique case (phase_q)
                PH_ACTIVE: if (count_d == FRONT_START) phase_d = PH_FRONT;
                PH_FRONT:  if (count_d == SYNC_START)  phase_d = PH_SYNC;
                PH_SYNC:   if (count_d == BACK_START)  phase_d = PH_BACK;
                PH_BACK:   if (count_d == '0)          phase_d = PH_ACTIVE;
            endcase
        end
    end

    // Counter and phase state; reset parks on the last back-porch count.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            count_q <= LAST;
            phase_q <= PH_BACK;
        end else begin
            count_q <= count_d;
            phase_q <= phase_d;
        end
    end

    assign Count = count_q;
    assign Phase = phase_d;
    assign Wrap  = (count_q == LAST);

endmodule

// File: rtl/vga_sync_gen.sv
// rtl/vga_sync_gen.sv - 640x480@60 VGA sync, visible flag, coordinates and line/frame strobes
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int H_VISIBLE = DEF_H_VISIBLE,
    parameter int H_FRONT   = DEF_H_FRONT,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BACK    = DEF_H_BACK,
    parameter int V_VISIBLE = DEF_V_VISIBLE,
    parameter int V_FRONT   = DEF_V_FRONT,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BACK    = DEF_V_BACK,
    parameter bit SYNC_POL  = 1'b0,
    parameter int CNT_W     = 10
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             PixEn,
    output logic             HSync,
    output logic             VSync,
    output logic             Video_on,
    output logic [CNT_W-1:0] PixelX,
    output logic [CNT_W-1:0] PixelY,
    output logic             LineStart,
    output logic             FrameStart
);

    phase_e h_phase_d, v_phase_d;
    logic   h_wrap, v_wrap;
    logic   v_en;

    logic hsync_q, vsync_q, video_on_q, line_start_q, frame_start_q;

    // The vertical axis steps once per line, on the pixel that wraps the horizontal axis.
    assign v_en = PixEn & h_wrap;

    vga_axis_timer #(
        .VISIBLE (H_VISIBLE),
        .FRONT   (H_FRONT),
        .SYNC    (H_SYNC),
        .BACK    (H_BACK),
        .CNT_W   (CNT_W)
    ) u_h_timer (
        .Clk   (Clk),
        .Rst   (Rst),
        .En    (PixEn),
        .Count (PixelX),
        .Phase (h_phase_d),
        .Wrap  (h_wrap)
    );

    vga_axis_timer #(
        .VISIBLE (V_VISIBLE),
        .FRONT   (V_FRONT),
        .SYNC    (V_SYNC),
        .BACK    (V_BACK),
        .CNT_W   (CNT_W)
    ) u_v_timer (
        .Clk   (Clk),
        .Rst   (Rst),
        .En    (v_en),
        .Count (PixelY),
        .Phase (v_phase_d),
        .Wrap  (v_wrap)
    );

    // Outputs are decoded from the phases the counters enter at this edge, so they line up with PixelX/PixelY.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            hsync_q       <= ~SYNC_POL;
            vsync_q       <= ~SYNC_POL;
            video_on_q    <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else if (PixEn) begin
            hsync_q       <= (h_phase_d == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
            vsync_q       <= (v_phase_d == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
            video_on_q    <= (h_phase_d == PH_ACTIVE) && (v_phase_d == PH_ACTIVE);
            line_start_q  <= h_wrap;
            frame_start_q <= h_wrap & v_wrap;
        end else begin
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end
    end

    assign HSync      = hsync_q;
    assign VSync      = vsync_q;
    assign Video_on   = video_on_q;
    assign LineStart  = line_start_q;
    assign FrameStart = frame_start_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb/tb_vga_sync_gen.sv - scoreboard bench: full-size timing plus a miniature timing for frame-level behaviour
module tb_vga_sync_gen;

    logic Clk = 1'b0;
    logic Rst = 1'b1;
    logic PixEn = 1'b0;

    logic       HSync, VSync, Video_on, LineStart, FrameStart;
    logic [9:0] PixelX, PixelY;
    logic       s_hs, s_vs, s_vid, s_ls, s_fs;
    logic [3:0] s_x, s_y;

    always #10 Clk = ~Clk;

    vga_sync_gen dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .PixEn      (PixEn),
        .HSync      (HSync),
        .VSync      (VSync),
        .Video_on   (Video_on),
        .PixelX     (PixelX),
        .PixelY     (PixelY),
        .LineStart  (LineStart),
        .FrameStart (FrameStart)
    );

    // 15 pixels x 8 lines: sync at x 10..12, y 5..6; a frame is 120 PixEn.
    vga_sync_gen #(
        .H_VISIBLE (8), .H_FRONT (2), .H_SYNC (3), .H_BACK (2),
        .V_VISIBLE (4), .V_FRONT (1), .V_SYNC (2), .V_BACK (1),
        .SYNC_POL  (1'b0), .CNT_W (4)
    ) dut_s (
        .Clk        (Clk),
        .Rst        (Rst),
        .PixEn      (PixEn),
        .HSync      (s_hs),
        .VSync      (s_vs),
        .Video_on   (s_vid),
        .PixelX     (s_x),
        .PixelY     (s_y),
        .LineStart  (s_ls),
        .FrameStart (s_fs)
    );

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       hs;
        logic       vs;
        logic       vid;
        logic       ls;
        logic       fs;
    } obs_t;

    obs_t q_big[$];
    obs_t q_small[$];
    obs_t e_b, a_b, e_s, a_s;

    int n_pass  = 0;
    int n_total = 0;

    // Reference timing: index 0 = full 640x480, index 1 = miniature.
    int HV [2] = '{640, 8};
    int HF [2] = '{16, 2};
    int HS [2] = '{96, 3};
    int HB [2] = '{48, 2};
    int VV [2] = '{480, 4};
    int VF [2] = '{10, 1};
    int VS [2] = '{2, 2};
    int VB [2] = '{33, 1};

    int   mx [2];
    int   my [2];
    logic mls [2];
    logic mfs [2];

    int en_cnt     = 0;
    bit track      = 1'b1;
    int hs_min     = 9999;
    int hs_max     = -1;
    int vid_fall_x = -1;
    logic prev_vid = 1'b0;
    int last_ls    = -1;
    int last_fs_s  = -1;
    int vs_min_s   = 9999;
    int vs_max_s   = -1;

    task automatic check(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic obs_t model_out(input int i);
        obs_t o;
        int   hs0, vs0;
        hs0   = HV[i] + HF[i];
        vs0   = VV[i] + VF[i];
        o.x   = 10'(mx[i]);
        o.y   = 10'(my[i]);
        o.hs  = !(mx[i] >= hs0 && mx[i] < hs0 + HS[i]);
        o.vs  = !(my[i] >= vs0 && my[i] < vs0 + VS[i]);
        o.vid = (mx[i] < HV[i]) && (my[i] < VV[i]);
        o.ls  = mls[i];
        o.fs  = mfs[i];
        return o;
    endfunction

    task automatic model_step(input int i, input logic r, input logic e);
        int ht, vt;
        ht = HV[i] + HF[i] + HS[i] + HB[i];
        vt = VV[i] + VF[i] + VS[i] + VB[i];
        if (r) begin
            mx[i] = ht - 1; my[i] = vt - 1; mls[i] = 1'b0; mfs[i] = 1'b0;
        end else if (e) begin
            if (mx[i] == ht - 1) begin
                mx[i] = 0;
                my[i] = (my[i] == vt - 1) ? 0 : my[i] + 1;
            end else begin
                mx[i] = mx[i] + 1;
            end
            mls[i] = (mx[i] == 0);
            mfs[i] = (mx[i] == 0) && (my[i] == 0);
        end else begin
            mls[i] = 1'b0; mfs[i] = 1'b0;
        end
    endtask

    // One Clk cycle of stimulus; the expected outputs after that edge go to the scoreboards.
    task automatic drive(input logic r, input logic e);
        @(negedge Clk);
        Rst = r;
        PixEn = e;
        @(posedge Clk);
        #1;
        model_step(0, r, e);
        model_step(1, r, e);
        q_big.push_back(model_out(0));
        q_small.push_back(model_out(1));
        if (e && !r) en_cnt++;
    endtask

    // Monitor: compares every presented cycle and gathers interval statistics.
    always @(negedge Clk) begin
        if (q_big.size() > 0) begin
            e_b = q_big.pop_front();
            a_b = {PixelX, PixelY, HSync, VSync, Video_on, LineStart, FrameStart};
            check("big_outputs", longint'(a_b), longint'(e_b));
            if (track) begin
                if (!HSync) begin
                    if (int'(PixelX) < hs_min) hs_min = int'(PixelX);
                    if (int'(PixelX) > hs_max) hs_max = int'(PixelX);
                end
                if (prev_vid && !Video_on && vid_fall_x < 0) vid_fall_x = int'(PixelX);
                if (LineStart) begin
                    if (last_ls >= 0) check("line_period", en_cnt - last_ls, 800);
                    last_ls = en_cnt;
                end
            end
            prev_vid = Video_on;
        end
        if (q_small.size() > 0) begin
            e_s = q_small.pop_front();
            a_s = {6'd0, s_x, 6'd0, s_y, s_hs, s_vs, s_vid, s_ls, s_fs};
            check("small_outputs", longint'(a_s), longint'(e_s));
            if (track) begin
                if (!s_vs) begin
                    if (int'(s_y) < vs_min_s) vs_min_s = int'(s_y);
                    if (int'(s_y) > vs_max_s) vs_max_s = int'(s_y);
                end
                if (s_fs) begin
                    if (last_fs_s >= 0) check("small_frame_period", en_cnt - last_fs_s, 120);
                    last_fs_s = en_cnt;
                end
            end
        end
    end

    initial begin
        // Reset held with PixEn toggling.
        drive(1'b1, 1'b1);
        drive(1'b1, 1'b0);
        drive(1'b1, 1'b1);
        check("rst_x", PixelX, 799);
        check("rst_y", PixelY, 524);
        check("rst_hsync", HSync, 1);
        check("rst_vsync", VSync, 1);
        check("rst_video", Video_on, 0);
        check("rst_ls", LineStart, 0);
        check("rst_fs", FrameStart, 0);

        // Release; first PixEn lands on (0,0).
        drive(1'b0, 1'b0);
        check("idle_x", PixelX, 799);
        drive(1'b0, 1'b1);
        check("first_x", PixelX, 0);
        check("first_y", PixelY, 0);
        check("first_video", Video_on, 1);
        check("first_ls", LineStart, 1);
        check("first_fs", FrameStart, 1);
        drive(1'b0, 1'b0);
        check("ls_one_cycle", LineStart, 0);
        check("fs_one_cycle", FrameStart, 0);

        // PixEn every second Clk across a full line and into the next.
        for (int k = 0; k < 1640; k++) drive(1'b0, 1'(k % 2));
        check("video_fall_x", vid_fall_x, 640);
        check("hsync_first_x", hs_min, 656);
        check("hsync_last_x", hs_max, 751);

        // Continuous PixEn up to x=300, then freeze.
        for (int k = 0; k < 2000 && mx[0] != 300; k++) drive(1'b0, 1'b1);
        check("at_300", PixelX, 300);
        for (int k = 0; k < 10; k++) drive(1'b0, 1'b0);
        check("frozen_x", PixelX, 300);
        check("frozen_y", PixelY, 1);
        check("frozen_ls", LineStart, 0);
        check("frozen_video", Video_on, 1);
        for (int k = 0; k < 5; k++) drive(1'b0, 1'b1);
        check("continuous_x", PixelX, 305);

        // Run on to (300,2), collecting miniature frames on the way.
        for (int k = 0; k < 3000 && !(mx[0] == 300 && my[0] == 2); k++) drive(1'b0, 1'b1);
        check("at_300_2_y", PixelY, 2);
        check("small_vsync_first_y", vs_min_s, 5);
        check("small_vsync_last_y", vs_max_s, 6);

        // Reset mid-frame together with PixEn.
        track = 1'b0;
        drive(1'b1, 1'b1);
        check("midrst_x", PixelX, 799);
        check("midrst_y", PixelY, 524);
        check("midrst_hsync", HSync, 1);
        drive(1'b0, 1'b0);
        drive(1'b0, 1'b1);
        check("after_rst_x", PixelX, 0);
        check("after_rst_y", PixelY, 0);
        check("after_rst_fs", FrameStart, 1);

        @(negedge Clk);
        @(negedge Clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
